// File: rtl/vga_ram_reader.sv
// Fetches one 160-bit text row from display RAM and streams it out as 40 hex nibbles.
// Optional leading-zero blanking per field is compiled in with VGA_READER_BLANK_EN.
module vga_ram_reader #(
   parameter int ROWS     = 46,
   parameter int REG_ROWS = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         line_req,
   input  logic [5:0]   line_idx,
   output logic [31:0]  read_address,
   input  logic [159:0] ram_out,
   output logic         nib_valid,
   input  logic         nib_ready,
   output logic [3:0]   nib_data,
   output logic [5:0]   nib_col,
   output logic [1:0]   nib_field,
   output logic         nib_blank,
   output logic         busy,
   output logic         line_done,
   output logic         overrun_err,
   input  logic         clr_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LATCH,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [5:0] LAST_COL = 6'd39;

   state_t         state_q, state_d;
   logic [5:0]     idx_q, idx_d;
   logic [159:0]   shift_q, shift_d;
   logic [5:0]     col_q, col_d;
   logic           err_q, err_d;
   logic [159:0]   row_data;
   logic           accept;
   logic           field_last;

   // Rows beyond the register file or the display memory read back as zeros.
   always_comb begin
      row_data = ram_out;
      if (32'(idx_q) >= REG_ROWS) begin
         row_data[95:64] = '0;
      end
      if (32'(idx_q) >= ROWS) begin
         row_data = '0;
      end
   end

   assign accept     = (state_q == S_SHIFT) && nib_ready;
   assign field_last = (col_q == 6'd15) || (col_q == 6'd23) || (col_q == LAST_COL);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      col_d   = col_q;
      case (state_q)
         S_IDLE: begin
            if (line_req) begin
               idx_d   = line_idx;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            shift_d = row_data;
            col_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (nib_ready) begin
               shift_d = {shift_q[155:0], 4'h0};
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = S_DONE;
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A request seen in any non-idle state is dropped; a new overrun beats clr_err.
   always_comb begin
      err_d = err_q;
      if (clr_err) begin
         err_d = 1'b0;
      end
      if (line_req && (state_q != S_IDLE)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         col_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         col_q   <= col_d;
         err_q   <= err_d;
      end
   end

`ifdef VGA_READER_BLANK_EN
   logic seen_q, seen_d;

   // seen tracks whether a nonzero nibble has already gone out in the current field.
   always_comb begin
      seen_d = seen_q;
      if (state_q == S_LATCH) begin
         seen_d = 1'b0;
      end else if (accept) begin
         if (field_last) begin
            seen_d = 1'b0;
         end else if (shift_q[159:156] != 4'h0) begin
            seen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

   assign nib_blank = (state_q == S_SHIFT) && (shift_q[159:156] == 4'h0) &&
                      !seen_q && !field_last;
`else
   assign nib_blank = 1'b0;
`endif

   assign busy         = (state_q != S_IDLE);
   assign line_done    = (state_q == S_DONE);
   assign nib_valid    = (state_q == S_SHIFT);
   assign nib_data     = shift_q[159:156];
   assign nib_col      = col_q;
   assign overrun_err  = err_q;
   assign read_address = ((state_q == S_ADDR) || (state_q == S_LATCH)) ? {26'd0, idx_q} : 32'd0;

   always_comb begin
      if (col_q < 6'd16) begin
         nib_field = 2'd0;
      end else if (col_q < 6'd24) begin
         nib_field = 2'd1;
      end else begin
         nib_field = 2'd2;
      end
   end

endmodule

// File: tb/tb_vga_ram_reader.sv
// Directed bench for vga_ram_reader: a small RAM array answers read_address combinationally.
module tb_vga_ram_reader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         line_req;
   logic [5:0]   line_idx;
   logic [31:0]  read_address;
   logic [159:0] ram_out;
   logic         nib_valid;
   logic         nib_ready;
   logic [3:0]   nib_data;
   logic [5:0]   nib_col;
   logic [1:0]   nib_field;
   logic         nib_blank;
   logic         busy;
   logic         line_done;
   logic         overrun_err;
   logic         clr_err;

   int checks   = 0;
   int failures = 0;

   logic [159:0] mem [64];

   localparam logic [159:0] PAT  = {64'h0123456789ABCDEF, 32'h89ABCDEF, 64'h0123456789ABCDEF};
   localparam logic [159:0] PAT2 = {64'hFEDCBA9876543210, 32'h13579BDF, 64'h02468ACE13579BDF};

   assign ram_out = mem[read_address[5:0]];

   vga_ram_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .line_req     (line_req),
      .line_idx     (line_idx),
      .read_address (read_address),
      .ram_out      (ram_out),
      .nib_valid    (nib_valid),
      .nib_ready    (nib_ready),
      .nib_data     (nib_data),
      .nib_col      (nib_col),
      .nib_field    (nib_field),
      .nib_blank    (nib_blank),
      .busy         (busy),
      .line_done    (line_done),
      .overrun_err  (overrun_err),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] nib_of(input logic [159:0] v, input int c);
      return v[159-4*c -: 4];
   endfunction

   function automatic logic [1:0] field_of(input int c);
      if (c < 16) return 2'd0;
      if (c < 24) return 2'd1;
      return 2'd2;
   endfunction

   // Pulses line_req for one cycle and returns at the first SHIFT sample point.
   task automatic start_line(input logic [5:0] idx);
      line_idx = idx;
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      line_req = 1'b1;
      line_idx = 6'd3;
      nib_ready = 1'b1;
      clr_err  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({read_address, nib_valid, nib_data, nib_col, nib_field, nib_blank, busy, line_done, overrun_err} !== 51'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {read_address, nib_valid, nib_data, nib_col, nib_field, nib_blank, busy, line_done, overrun_err});
      end
      line_req = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_basic;
      nib_ready = 1'b1;
      line_idx  = 6'd3;
      line_req  = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
      checks++;
      if ({read_address, busy, nib_valid} !== {32'd3, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL basic_addr got addr=%0d busy=%b vld=%b exp addr=3 busy=1 vld=0", read_address, busy, nib_valid);
      end
      @(negedge clk);
      checks++;
      if ({read_address, nib_valid} !== {32'd3, 1'b0}) begin
         failures++;
         $display("FAIL basic_latch got addr=%0d vld=%b exp addr=3 vld=0", read_address, nib_valid);
      end
      @(negedge clk);
      for (int c = 0; c < 40; c++) begin
         checks++;
         if ({nib_valid, nib_data, nib_col, nib_field, read_address} !==
             {1'b1, nib_of(PAT, c), 6'(c), field_of(c), 32'd0}) begin
            failures++;
            $display("FAIL basic_nibble col=%0d got vld=%b d=%h col=%0d f=%0d addr=%0d exp d=%h f=%0d",
                     c, nib_valid, nib_data, nib_col, nib_field, read_address, nib_of(PAT, c), field_of(c));
         end
         @(negedge clk);
      end
      checks++;
      if ({line_done, nib_valid, busy} !== 3'b101) begin
         failures++;
         $display("FAIL basic_done got done=%b vld=%b busy=%b exp 1 0 1", line_done, nib_valid, busy);
      end
      @(negedge clk);
      checks++;
      if ({line_done, busy} !== 2'b00) begin
         failures++;
         $display("FAIL basic_idle got done=%b busy=%b exp 0 0", line_done, busy);
      end
   endtask

   task automatic test_handshake;
      int k;
      int cyc;
      nib_ready = 1'b0;
      start_line(6'd5);
      k   = 0;
      cyc = 0;
      while (nib_valid === 1'b1 && cyc < 200) begin
         checks++;
         if ({nib_data, nib_col, nib_field} !== {nib_of(PAT2, k), 6'(k), field_of(k)}) begin
            failures++;
            $display("FAIL handshake_nibble cyc=%0d got d=%h col=%0d exp d=%h col=%0d",
                     cyc, nib_data, nib_col, nib_of(PAT2, k), k);
         end
         nib_ready = (cyc % 2 == 1);
         if (nib_ready) k++;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (cyc !== 80 || k !== 40) begin
         failures++;
         $display("FAIL handshake_length got cycles=%0d nibbles=%0d exp cycles=80 nibbles=40", cyc, k);
      end
      checks++;
      if (line_done !== 1'b1) begin
         failures++;
         $display("FAIL handshake_done got=%b exp=1", line_done);
      end
      nib_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_row_limits;
      logic [5:0]   idxs [5];
      logic [159:0] exps [5];
      idxs = '{6'd31, 6'd40, 6'd45, 6'd46, 6'd50};
      exps = '{{64'h5555555555555555, 32'hDEADBEEF, 64'h6666666666666666},
               {64'h1111111111111111, 32'h00000000, 64'h2222222222222222},
               {64'h7777777777777777, 32'h00000000, 64'h8888888888888888},
               160'd0,
               160'd0};
      nib_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         start_line(idxs[r]);
         for (int c = 0; c < 40; c++) begin
            checks++;
            if ({nib_valid, nib_data} !== {1'b1, nib_of(exps[r], c)}) begin
               failures++;
               $display("FAIL rows_nibble row=%0d col=%0d got vld=%b d=%h exp d=%h",
                        idxs[r], c, nib_valid, nib_data, nib_of(exps[r], c));
            end
            @(negedge clk);
         end
         checks++;
         if (line_done !== 1'b1) begin
            failures++;
            $display("FAIL rows_done row=%0d got=%b exp=1", idxs[r], line_done);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_overrun;
      int n;
      nib_ready = 1'b1;
      start_line(6'd3);
      line_idx = 6'd7;
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
      checks++;
      if ({overrun_err, nib_col, read_address} !== {1'b1, 6'd1, 32'd0}) begin
         failures++;
         $display("FAIL overrun_set got err=%b col=%0d addr=%0d exp err=1 col=1 addr=0", overrun_err, nib_col, read_address);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++;
      if (overrun_err !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear got=%b exp=0", overrun_err);
      end
      clr_err  = 1'b1;
      line_req = 1'b1;
      @(negedge clk);
      clr_err  = 1'b0;
      line_req = 1'b0;
      checks++;
      if (overrun_err !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set_wins got=%b exp=1", overrun_err);
      end
      n = 0;
      while (line_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (line_done !== 1'b1) begin
         failures++;
         $display("FAIL overrun_line_done got=%b exp=1 after %0d cycles", line_done, n);
      end
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
      checks++;
      if ({busy, overrun_err} !== 2'b01) begin
         failures++;
         $display("FAIL overrun_done_req got busy=%b err=%b exp busy=0 err=1", busy, overrun_err);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++;
      if ({busy, overrun_err} !== 2'b00) begin
         failures++;
         $display("FAIL overrun_final got busy=%b err=%b exp 0 0", busy, overrun_err);
      end
   endtask

   task automatic test_reset_midline;
      int n;
      logic seen_done;
      nib_ready = 1'b1;
      start_line(6'd3);
      n = 0;
      while (nib_col !== 6'd20 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (nib_col !== 6'd20) begin
         failures++;
         $display("FAIL midreset_reach got col=%0d exp=20", nib_col);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({read_address, nib_valid, nib_data, nib_col, nib_field, nib_blank, busy, line_done, overrun_err} !== 51'd0) begin
         failures++;
         $display("FAIL midreset_async got=%h exp=0",
                  {read_address, nib_valid, nib_data, nib_col, nib_field, nib_blank, busy, line_done, overrun_err});
      end
      seen_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (line_done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         failures++;
         $display("FAIL midreset_no_done got activity=%b exp=0", seen_done);
      end
      rst_n    = 1'b1;
      line_idx = 6'd3;
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
      checks++;
      if ({read_address, busy} !== {32'd3, 1'b1}) begin
         failures++;
         $display("FAIL midreset_first_req got addr=%0d busy=%b exp addr=3 busy=1", read_address, busy);
      end
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 40; c++) begin
         checks++;
         if ({nib_valid, nib_data, nib_col} !== {1'b1, nib_of(PAT, c), 6'(c)}) begin
            failures++;
            $display("FAIL midreset_nibble col=%0d got vld=%b d=%h col=%0d exp d=%h",
                     c, nib_valid, nib_data, nib_col, nib_of(PAT, c));
         end
         @(negedge clk);
      end
      checks++;
      if (line_done !== 1'b1) begin
         failures++;
         $display("FAIL midreset_done got=%b exp=1", line_done);
      end
      @(negedge clk);
   endtask

   task automatic test_blank;
      logic exp_blank;
      nib_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         start_line(r == 0 ? 6'd9 : 6'd10);
         for (int c = 0; c < 40; c++) begin
`ifdef VGA_READER_BLANK_EN
            exp_blank = ((r == 0) ? (c <= 13) : (c <= 14)) ||
                        (c >= 16 && c <= 22) || (c >= 24 && c <= 38);
`else
            exp_blank = 1'b0;
`endif
            checks++;
            if ({nib_valid, nib_blank} !== {1'b1, exp_blank}) begin
               failures++;
               $display("FAIL blank row=%0d col=%0d got vld=%b blank=%b exp blank=%b",
                        r, c, nib_valid, nib_blank, exp_blank);
            end
            @(negedge clk);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = {40{4'hA}};
      mem[3]  = PAT;
      mem[5]  = PAT2;
      mem[31] = {64'h5555555555555555, 32'hDEADBEEF, 64'h6666666666666666};
      mem[40] = {64'h1111111111111111, 32'hDEADBEEF, 64'h2222222222222222};
      mem[45] = {64'h7777777777777777, 32'hDEADBEEF, 64'h8888888888888888};
      mem[46] = {64'h9999999999999999, 32'hDEADBEEF, 64'h9999999999999999};
      mem[50] = {64'h3333333333333333, 32'hDEADBEEF, 64'h4444444444444444};
      mem[9]  = {64'h0000000000000013, 32'h0, 64'h0};
      mem[10] = 160'd0;
      test_reset();
      test_basic();
      test_handshake();
      test_row_limits();
      test_overrun();
      test_reset_midline();
      test_blank();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
